video_pixel_tracker: RTL and testbench

Writer-side front end for the line-buffered HDMI framebuffer. It runs in the Mega Drive core clock domain and converts the core's raw pixel stream into the addressed pixel writes the framebuffer consumes. The raw stream is a pixel strobe, blanking flags and RGB. The writes are a strobe, RGB, x, y, and measured frame width/height. Frame geometry is measured each frame and published only after two identical consecutive frames, so scaler counters never see a glitched mode.

---
 rtl/video_pkg.sv | 17 +
 rtl/video_geom_filter.sv | 57 +++++
 rtl/video_pixel_tracker.sv | 215 +++++++++++++++++++++
 tb/tb_video_pixel_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and counter widths for the video pixel tracker.
//   tracker_state_t : line/frame tracking states
//   XCNT_BITS       : width of the internal column counter and measured width
//   YCNT_BITS       : width of the internal row counter and measured height
package video_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    HBL    = 2'd2,
    VBL    = 2'd3
  } tracker_state_t;

  localparam int XCNT_BITS = 11;
  localparam int YCNT_BITS = 10;

endpackage

// File: rtl/video_geom_filter.sv
// Frame geometry stability filter.
// A measurement is published only when it matches the measurement of the
// previous frame, so downstream scalers never see a one-frame glitch.
//   clk, reset          : core clock, synchronous active-high reset
//   meas_valid          : one-clk strobe at frame end
//   meas_w, meas_h      : clamped geometry measured for the frame just ended
//   width, height       : published geometry (reset to WIDTH x HEIGHT)
//   geom_valid          : high once any geometry has been published
module video_geom_filter
  import video_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 meas_valid,
  input  logic [XCNT_BITS-1:0] meas_w,
  input  logic [YCNT_BITS-1:0] meas_h,
  output logic [XCNT_BITS-1:0] width,
  output logic [YCNT_BITS-1:0] height,
  output logic                 geom_valid
);

  logic [XCNT_BITS-1:0] r_cand_w;
  logic [YCNT_BITS-1:0] r_cand_h;
  logic [XCNT_BITS-1:0] r_width;
  logic [YCNT_BITS-1:0] r_height;
  logic                 r_valid;
  logic                 w_match;

  assign w_match = (meas_w == r_cand_w) && (meas_h == r_cand_h);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand_w <= '0;
      r_cand_h <= '0;
      r_width  <= XCNT_BITS'(WIDTH);
      r_height <= YCNT_BITS'(HEIGHT);
      r_valid  <= 1'b0;
    end else if (meas_valid) begin
      if (w_match) begin
        r_width  <= meas_w;
        r_height <= meas_h;
        r_valid  <= 1'b1;
      end
      // On a match the candidate is unchanged; otherwise it becomes the new one.
      r_cand_w <= meas_w;
      r_cand_h <= meas_h;
    end
  end

  assign width      = r_width;
  assign height     = r_height;
  assign geom_valid = r_valid;

endmodule

// File: rtl/video_pixel_tracker.sv
// Writer-side front end for the line-buffered framebuffer.
// Converts the core's raw pixel stream (strobe, blanking, RGB) into addressed
// pixel writes and measures the frame geometry every frame.
//   clk, reset               : core clock, synchronous active-high reset
//   ce_pix_in                : raw pixel strobe (may be held for several clks)
//   hblank, vblank           : blanking flags, sampled at pixel events
//   r_in, g_in, b_in         : pixel colour
//   ce_pix, r, g, b, x, y    : registered pixel write
//   width, height            : published active geometry
//   frame_start              : one-clk pulse when a frame's active region opens
//   geom_valid               : high once any geometry has been published
module video_pixel_tracker
  import video_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int COLOR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_pix_in,
  input  logic                      hblank,
  input  logic                      vblank,
  input  logic [COLOR_BITS-1:0]     r_in,
  input  logic [COLOR_BITS-1:0]     g_in,
  input  logic [COLOR_BITS-1:0]     b_in,
  output logic                      ce_pix,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic [XCNT_BITS-1:0]      width,
  output logic [YCNT_BITS-1:0]      height,
  output logic                      frame_start,
  output logic                      geom_valid
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XCNT_BITS-1:0] L_WIDTH  = XCNT_BITS'(WIDTH);
  localparam logic [YCNT_BITS-1:0] L_HEIGHT = YCNT_BITS'(HEIGHT);

  function automatic logic [XCNT_BITS-1:0] sat_inc_x(input logic [XCNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [YCNT_BITS-1:0] sat_inc_y(input logic [YCNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [XCNT_BITS-1:0] clamp_w(input logic [XCNT_BITS-1:0] v);
    return (v > L_WIDTH) ? L_WIDTH : v;
  endfunction

  function automatic logic [YCNT_BITS-1:0] clamp_h(input logic [YCNT_BITS-1:0] v);
    return (v > L_HEIGHT) ? L_HEIGHT : v;
  endfunction

  tracker_state_t       r_state, w_state_nxt;
  logic                 r_ce_q;
  logic                 r_sync_vb, w_sync_vb_nxt;
  logic [XCNT_BITS-1:0] r_xcnt, w_xcnt_nxt;
  logic [XCNT_BITS-1:0] r_maxw, w_maxw_nxt, w_maxw_le;
  logic [YCNT_BITS-1:0] r_ycnt, w_ycnt_nxt, w_ycnt_le;
  logic                 w_evt, w_pix_evt, w_pix, w_fs, w_frame_end;
  logic [XCNT_BITS-1:0] w_meas_w;
  logic [YCNT_BITS-1:0] w_meas_h;

  logic                  r_ce_pix, r_fs;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [COLOR_BITS-1:0] r_red, r_grn, r_blu;

  // A held strobe counts once: only its rising edge is an event.
  assign w_evt = ce_pix_in & ~r_ce_q;

  always_ff @(posedge clk) begin
    if (reset) r_state <= SYNC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sync_vb_nxt = r_sync_vb;
    w_xcnt_nxt    = r_xcnt;
    w_ycnt_nxt    = r_ycnt;
    w_maxw_nxt    = r_maxw;
    w_pix_evt     = 1'b0;
    w_fs          = 1'b0;
    w_frame_end   = 1'b0;

    // Values after closing the current line; a frame end seen while still in
    // ACTIVE closes the line first so the last line is counted.
    w_maxw_le = (r_xcnt > r_maxw) ? r_xcnt : r_maxw;
    w_ycnt_le = (r_xcnt != '0) ? sat_inc_y(r_ycnt) : r_ycnt;
    if (r_state == ACTIVE) begin
      w_meas_w = clamp_w(w_maxw_le);
      w_meas_h = clamp_h(w_ycnt_le);
    end else begin
      w_meas_w = clamp_w(r_maxw);
      w_meas_h = clamp_h(r_ycnt);
    end

    if (w_evt) begin
      case (r_state)
        SYNC: begin
          if (vblank) begin
            w_sync_vb_nxt = 1'b1;
          end else if (r_sync_vb) begin
            w_sync_vb_nxt = 1'b0;
            w_fs          = 1'b1;
            w_state_nxt   = hblank ? HBL : ACTIVE;
            w_pix_evt     = ~hblank;
          end
        end
        VBL: begin
          if (!vblank) begin
            w_fs        = 1'b1;
            w_state_nxt = hblank ? HBL : ACTIVE;
            w_pix_evt   = ~hblank;
          end
        end
        HBL: begin
          if (vblank) begin
            w_frame_end = 1'b1;
          end else if (!hblank) begin
            w_state_nxt = ACTIVE;
            w_pix_evt   = 1'b1;
          end
        end
        ACTIVE: begin
          if (vblank) begin
            w_frame_end = 1'b1;
          end else if (hblank) begin
            w_maxw_nxt  = w_maxw_le;
            w_ycnt_nxt  = w_ycnt_le;
            w_xcnt_nxt  = '0;
            w_state_nxt = HBL;
          end else begin
            w_pix_evt = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (w_frame_end) begin
      w_maxw_nxt  = '0;
      w_ycnt_nxt  = '0;
      w_xcnt_nxt  = '0;
      w_state_nxt = VBL;
    end

    if (w_pix_evt) w_xcnt_nxt = sat_inc_x(r_xcnt);

    // Pixels beyond the stored area are counted but never written.
    w_pix = w_pix_evt && (r_xcnt < L_WIDTH) && (r_ycnt < L_HEIGHT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ce_q    <= 1'b0;
      r_sync_vb <= 1'b0;
      r_xcnt    <= '0;
      r_ycnt    <= '0;
      r_maxw    <= '0;
      r_ce_pix  <= 1'b0;
      r_fs      <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
    end else begin
      r_ce_q    <= ce_pix_in;
      r_sync_vb <= w_sync_vb_nxt;
      r_xcnt    <= w_xcnt_nxt;
      r_ycnt    <= w_ycnt_nxt;
      r_maxw    <= w_maxw_nxt;
      r_ce_pix  <= w_pix;
      r_fs      <= w_fs;
      if (w_pix) begin
        r_x   <= r_xcnt[XW-1:0];
        r_y   <= r_ycnt[YW-1:0];
        r_red <= r_in;
        r_grn <= g_in;
        r_blu <= b_in;
      end
    end
  end

  video_geom_filter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_geom (
    .clk        (clk),
    .reset      (reset),
    .meas_valid (w_frame_end),
    .meas_w     (w_meas_w),
    .meas_h     (w_meas_h),
    .width      (width),
    .height     (height),
    .geom_valid (geom_valid)
  );

  assign ce_pix      = r_ce_pix;
  assign frame_start = r_fs;
  assign x           = r_x;
  assign y           = r_y;
  assign r           = r_red;
  assign g           = r_grn;
  assign b           = r_blu;

endmodule

// File: tb/tb_video_pixel_tracker.sv
module tb_video_pixel_tracker;

  localparam int WIDTH_P  = 320;
  localparam int HEIGHT_P = 240;
  localparam int CB       = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce_pix_in = 1'b0;
  logic          hblank = 1'b0;
  logic          vblank = 1'b0;
  logic [CB-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          ce_pix;
  logic [CB-1:0] r, g, b;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [10:0]   width;
  logic [9:0]    height;
  logic          frame_start;
  logic          geom_valid;

  video_pixel_tracker #(.WIDTH(WIDTH_P), .HEIGHT(HEIGHT_P), .COLOR_BITS(CB)) dut (
    .clk(clk), .reset(reset), .ce_pix_in(ce_pix_in), .hblank(hblank), .vblank(vblank),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .ce_pix(ce_pix), .r(r), .g(g), .b(b),
    .x(x), .y(y), .width(width), .height(height), .frame_start(frame_start),
    .geom_valid(geom_valid)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    longint      cyc;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int len;
    int last_len;
    int lines;
    int hold;
    bit simul;
    int exp_w;
    int exp_h;
    bit exp_v;
  } fvec_t;
  fvec_t tbl[12];

  int     g_lens[$];
  int     m_pub_w, m_pub_h, m_cand_w, m_cand_h;
  bit     m_valid;
  int     fs_cnt = 0;
  longint fs_last = -1;

  // Write scoreboard and frame_start monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_last = cyc;
    end
    if (ce_pix) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got x=%0d y=%0d cyc=%0d required none", x, y, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(x) != e.x || int'(y) != e.y || {r, g, b} != e.rgb || cyc != e.cyc) begin
          failures++;
          $display("FAIL write got x=%0d y=%0d rgb=%h cyc=%0d required x=%0d y=%0d rgb=%h cyc=%0d",
                   x, y, {r, g, b}, cyc, e.x, e.y, e.rgb, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic model_reset();
    m_pub_w  = WIDTH_P;
    m_pub_h  = HEIGHT_P;
    m_valid  = 1'b0;
    m_cand_w = 0;
    m_cand_h = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; ce_pix_in = 1'b0; hblank = 1'b0; vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset_strobes_coords_rgb", {ce_pix, frame_start, geom_valid, x, y, r, g, b}, 0);
    chk("reset_width", width, WIDTH_P);
    chk("reset_height", height, HEIGHT_P);
  endtask

  // One raw pixel event: strobe held for 'hold' clks, then low for 'gap' clks.
  task automatic ev(input bit hb, input bit vb, input bit expw, input int xe, input int ye,
                    input int hold, input int gap, output longint ecyc);
    logic [3:0] rr, gg, bb;
    rr = 4'($urandom_range(0, 15));
    gg = 4'($urandom_range(0, 15));
    bb = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    ce_pix_in = 1'b1; hblank = hb; vblank = vb; r_in = rr; g_in = gg; b_in = bb;
    ecyc = cyc + 1;
    if (expw) exp_q.push_back('{x: xe, y: ye, rgb: {rr, gg, bb}, cyc: cyc + 1});
    repeat (hold) @(posedge clk);
    #1;
    ce_pix_in = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  // Sends one frame described by g_lens (active pixels per line). The expected
  // writes and geometry come from the frame description itself.
  task automatic run_frame(input int hold_f, input bit rnd, input bit simul, input int abort_line);
    int     hold, gap, k, maxl, fs0, nl, mw, mh;
    longint c, fall_c;
    bit     live;
    nl = g_lens.size(); live = 1'b1; k = 0; maxl = 0; fall_c = -2;
    hold = hold_f; gap = 1;
    for (int v = 0; v < 3; v++) ev(1'b1, 1'b1, 1'b0, 0, 0, hold, gap, c);
    fs0 = fs_cnt;
    for (int l = 0; l < nl; l++) begin
      if (l == abort_line) begin
        do_reset();
        live = 1'b0;
      end
      for (int h = 0; h < 2; h++) begin
        if (rnd) begin hold = $urandom_range(1, 3); gap = $urandom_range(1, 2); end
        ev(1'b1, 1'b0, 1'b0, 0, 0, hold, gap, c);
        if (l == 0 && h == 0) fall_c = c;
      end
      for (int i = 0; i < g_lens[l]; i++) begin
        if (rnd) begin hold = $urandom_range(1, 3); gap = $urandom_range(1, 2); end
        ev(1'b0, 1'b0, live && i < WIDTH_P && k < HEIGHT_P, i, k, hold, gap, c);
      end
      if (live && g_lens[l] > 0) begin
        k++;
        if (g_lens[l] > maxl) maxl = g_lens[l];
      end
      ev(1'b1, simul && (l == nl - 1), 1'b0, 0, 0, hold, gap, c);
    end
    for (int v = 0; v < 3; v++) ev(1'b1, 1'b1, 1'b0, 0, 0, hold, gap, c);
    repeat (3) @(posedge clk);
    #1;
    chk("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    chk("frame_start_count", fs_cnt - fs0, 1);
    chk("frame_start_time", fs_last, fall_c);
    if (live) begin
      mw = (maxl < WIDTH_P) ? maxl : WIDTH_P;
      mh = (k < HEIGHT_P) ? k : HEIGHT_P;
      if (mw == m_cand_w && mh == m_cand_h) begin
        m_pub_w = mw; m_pub_h = mh; m_valid = 1'b1;
      end
      m_cand_w = mw; m_cand_h = mh;
    end
    chk("model_width", width, m_pub_w);
    chk("model_height", height, m_pub_h);
    chk("model_geom_valid", geom_valid, m_valid);
  endtask

  task automatic set_lines(input int len, input int last_len, input int lines);
    g_lens.delete();
    for (int l = 0; l < lines; l++) g_lens.push_back((l == lines - 1) ? last_len : len);
  endtask

  initial begin
    // len, last_len, lines, hold, simul, published w, h, valid after the frame
    tbl[0]  = '{320, 320,   4, 1, 1'b0, 320, 240, 1'b0};
    tbl[1]  = '{320, 320,   4, 1, 1'b0, 320,   4, 1'b1};
    tbl[2]  = '{256, 256,   4, 1, 1'b0, 320,   4, 1'b1};
    tbl[3]  = '{256, 256,   4, 1, 1'b0, 256,   4, 1'b1};
    tbl[4]  = '{330, 330,   3, 1, 1'b0, 256,   4, 1'b1};
    tbl[5]  = '{330, 330,   3, 1, 1'b0, 320,   3, 1'b1};
    tbl[6]  = '{  2,   2, 250, 1, 1'b0, 320,   3, 1'b1};
    tbl[7]  = '{  2,   2, 250, 1, 1'b0,   2, 240, 1'b1};
    tbl[8]  = '{  3,   6,  30, 1, 1'b1,   2, 240, 1'b1};
    tbl[9]  = '{  3,   6,  30, 1, 1'b1,   6,  30, 1'b1};
    tbl[10] = '{  8,   8,   2, 5, 1'b0,   6,  30, 1'b1};
    tbl[11] = '{  8,   8,   2, 5, 1'b0,   8,   2, 1'b1};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      set_lines(tbl[i].len, tbl[i].last_len, tbl[i].lines);
      run_frame(tbl[i].hold, 1'b0, tbl[i].simul, -1);
      chk($sformatf("tbl%0d_width", i), width, tbl[i].exp_w);
      chk($sformatf("tbl%0d_height", i), height, tbl[i].exp_h);
      chk($sformatf("tbl%0d_geom_valid", i), geom_valid, tbl[i].exp_v);
    end

    // Randomised frames with random strobe hold/gap, each shown once or twice.
    for (int it = 0; it < 8; it++) begin
      int n, reps;
      bit sim;
      g_lens.delete();
      n = $urandom_range(1, 8);
      for (int l = 0; l < n; l++) g_lens.push_back($urandom_range(0, 12));
      reps = $urandom_range(1, 2);
      sim  = 1'($urandom_range(0, 1));
      for (int rp = 0; rp < reps; rp++) run_frame(1, 1'b1, sim, -1);
    end

    // Reset in the middle of a frame: the rest of it must produce nothing, and
    // the following frames restart from x=0, y=0 with default geometry.
    set_lines(6, 6, 10);
    run_frame(1, 1'b0, 1'b0, 5);
    chk("after_abort_geom_valid", geom_valid, 0);
    run_frame(1, 1'b0, 1'b0, -1);
    chk("post_reset_f1_width", width, WIDTH_P);
    chk("post_reset_f1_valid", geom_valid, 0);
    run_frame(1, 1'b0, 1'b0, -1);
    chk("post_reset_f2_width", width, 6);
    chk("post_reset_f2_height", height, 10);
    chk("post_reset_f2_valid", geom_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
